// File: rtl/img_loader.sv
// +-----------------------------------------------------------------------------+
// | Module   : img_loader                                                       |
// | Purpose  : Writes the ISP pixel stream into a ping-pong pair of layer-1     |
// |            SRAMs and tracks each buffer's full flag. Optional start-of-frame |
// |            checking is enabled with IMG_LOADER_FRAME_SYNC_EN.               |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module img_loader #(
  parameter int IMG_WIDTH  = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [IMG_WIDTH-1:0]  pix_data,
  output logic                  pix_ready,
`ifdef IMG_LOADER_FRAME_SYNC_EN
  input  logic                  pix_sof,
  output logic                  frame_err,
`endif
  input  logic                  img_request1,
  input  logic                  img_request2,
  output logic                  sram_en1,
  output logic                  sram_en2,
  output logic                  sram_wr1,
  output logic                  sram_wr2,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [IMG_WIDTH-1:0]  sram_dout,
  output logic                  sram_full1,
  output logic                  sram_full2
);

  localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sel;          // 0 = buffer 1, 1 = buffer 2
  logic [ADDR_WIDTH-1:0] r_wcnt;
  logic [ADDR_WIDTH-1:0] w_wcnt_nxt;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic                  w_we;
  logic                  w_err_set;
  logic                  w_accept;
  logic                  w_full_sel;
  logic                  w_req_sel;
  logic                  r_req1_q, r_req1_qq;
  logic                  r_req2_q, r_req2_qq;
  logic                  w_clr1, w_clr2;
  logic                  w_set1, w_set2;

  assign pix_ready  = (r_state == S_FILL);
  assign w_accept   = pix_valid & pix_ready;
  assign w_full_sel = r_sel ? sram_full2 : sram_full1;
  assign w_req_sel  = r_sel ? img_request2 : img_request1;

  // Request edges are taken from the registered copies, so a clear lands two cycles after the rise.
  assign w_clr1 = r_req1_q & ~r_req1_qq & sram_full1;
  assign w_clr2 = r_req2_q & ~r_req2_qq & sram_full2;
  assign w_set1 = (r_state == S_DONE) & ~r_sel;
  assign w_set2 = (r_state == S_DONE) &  r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_wcnt;
    w_wcnt_nxt  = r_wcnt;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_full_sel && w_req_sel) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (w_accept) begin
          w_we       = 1'b1;
          w_wcnt_nxt = r_wcnt + ADDR_WIDTH'(1);
`ifdef IMG_LOADER_FRAME_SYNC_EN
          // A stray sof restarts the frame at address 0; a missing sof drops the beat.
          if (pix_sof && (r_wcnt != '0)) begin
            w_waddr    = '0;
            w_wcnt_nxt = ADDR_WIDTH'(1);
            w_err_set  = 1'b1;
          end else if (!pix_sof && (r_wcnt == '0)) begin
            w_we       = 1'b0;
            w_wcnt_nxt = r_wcnt;
            w_err_set  = 1'b1;
          end else
`endif
          if (r_wcnt == c_last) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_wcnt     <= '0;
      sram_en1   <= 1'b1;
      sram_en2   <= 1'b1;
      sram_wr1   <= 1'b1;
      sram_wr2   <= 1'b1;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_full1 <= 1'b0;
      sram_full2 <= 1'b0;
      r_req1_q   <= 1'b0;
      r_req1_qq  <= 1'b0;
      r_req2_q   <= 1'b0;
      r_req2_qq  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      sram_en1  <= ~(w_we & ~r_sel);
      sram_wr1  <= ~(w_we & ~r_sel);
      sram_en2  <= ~(w_we &  r_sel);
      sram_wr2  <= ~(w_we &  r_sel);
      if (w_we) begin
        sram_addr <= w_waddr;
        sram_dout <= pix_data;
      end
      r_req1_q  <= img_request1;
      r_req1_qq <= r_req1_q;
      r_req2_q  <= img_request2;
      r_req2_qq <= r_req2_q;
      if (w_set1)      sram_full1 <= 1'b1;
      else if (w_clr1) sram_full1 <= 1'b0;
      if (w_set2)      sram_full2 <= 1'b1;
      else if (w_clr2) sram_full2 <= 1'b0;
      if (r_state == S_DONE) r_sel <= ~r_sel;
    end
  end

`ifdef IMG_LOADER_FRAME_SYNC_EN
  always_ff @(posedge clk) begin
    if (rst)            frame_err <= 1'b0;
    else if (w_err_set) frame_err <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = w_err_set;
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_loader.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_img_loader                                                    |
// | Purpose  : Directed self-checking bench for img_loader (ping-pong filling,  |
// |            full clear, stalls, mid-fill reset, optional frame sync).        |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_img_loader;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        pix_sof;
  logic        frame_err;
  logic        img_request1, img_request2;
  logic        sram_en1, sram_en2, sram_wr1, sram_wr2;
  logic [9:0]  sram_addr;
  logic [15:0] sram_dout;
  logic        sram_full1, sram_full2;

  int total = 0;
  int bad   = 0;
  int n1 = 0, n2 = 0;       // writes seen per buffer since last re-arm
  int tag1 = 0, tag2 = 0;   // expected data tag per buffer

  img_loader #(.IMG_WIDTH(16), .DEPTH(1024), .ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
`ifdef IMG_LOADER_FRAME_SYNC_EN
    .pix_sof      (pix_sof),
    .frame_err    (frame_err),
`endif
    .img_request1 (img_request1),
    .img_request2 (img_request2),
    .sram_en1     (sram_en1),
    .sram_en2     (sram_en2),
    .sram_wr1     (sram_wr1),
    .sram_wr2     (sram_wr2),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_full1   (sram_full1),
    .sram_full2   (sram_full2)
  );

`ifndef IMG_LOADER_FRAME_SYNC_EN
  assign frame_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write strobe must hit the next sequential address with the tagged data.
  always @(negedge clk) begin
    if (!sram_en1 || !sram_wr1) begin
      chk("w1_pair", {30'd0, sram_en1, sram_wr1}, 32'd0);
      chk("w1_addr", {22'd0, sram_addr}, n1);
      chk("w1_data", {16'd0, sram_dout}, {16'd0, tag1[5:0], n1[9:0]});
      n1++;
    end
    if (!sram_en2 || !sram_wr2) begin
      chk("w2_pair", {30'd0, sram_en2, sram_wr2}, 32'd0);
      chk("w2_addr", {22'd0, sram_addr}, n2);
      chk("w2_data", {16'd0, sram_dout}, {16'd0, tag2[5:0], n2[9:0]});
      n2++;
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends beats start..start+n-1; returns one cycle after the last accept.
  task automatic send(input int n, input int start, input int tag, input int gap, input int sof_at);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < n && guard < 20000) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data  = {tag[5:0], 10'(start + i)};
        pix_sof   = ((start + i) == sof_at);
      end
      @(negedge clk);
      acc = pix_valid & pix_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    if (i != n) chk("send_timeout", i, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    pix_sof = 1'b0;
    img_request1 = 1'b1;
    img_request2 = 1'b1;
    step(3);
    chk("rst_ctl", {25'd0, pix_ready, sram_en1, sram_wr1, sram_en2, sram_wr2, sram_full1, sram_full2},
        32'b0111100);
    chk("rst_addr", {22'd0, sram_addr}, 0);
    chk("rst_dout", {16'd0, sram_dout}, 0);
    chk("rst_err", {31'd0, frame_err}, 0);

    // Frame 1 -> SRAM1, data equals address.
    rst = 1'b0;
    tag1 = 0;
    send(1024, 0, 0, 0, 0);
    chk("f1_full_n1", {31'd0, sram_full1}, 0);
    chk("f1_ready_n1", {31'd0, pix_ready}, 0);
    step(1);
    chk("f1_full_n2", {30'd0, sram_full1, sram_full2}, 32'b10);
    chk("f1_cnt1", n1, 1024);
    chk("f1_cnt2", n2, 0);

    // Frame 2 -> SRAM2.
    tag2 = 2;
    send(1024, 0, 2, 0, 0);
    step(1);
    chk("f2_full", {30'd0, sram_full1, sram_full2}, 32'b11);
    chk("f2_cnt2", n2, 1024);
    chk("f2_cnt1", n1, 1024);

    // Both full: loader must hold off.
    step(5);
    chk("stall_ready", {31'd0, pix_ready}, 0);

    // Release buffer 1 with a request pulse; rise lands at cycle R.
    img_request1 = 1'b0;
    step(3);
    n1 = 0;
    tag1 = 3;
    img_request1 = 1'b1;
    chk("clr_R", {31'd0, sram_full1}, 1);
    step(1);
    chk("clr_R1", {31'd0, sram_full1}, 1);
    step(1);
    chk("clr_R2", {31'd0, sram_full1}, 0);
    chk("clr_full2", {31'd0, sram_full2}, 1);

    // Refill SRAM1 with ~30% idle cycles.
    send(1024, 0, 3, 30, 0);
    step(1);
    chk("gap_cnt1", n1, 1024);
    chk("gap_full1", {31'd0, sram_full1}, 1);

    // Reset in the middle of a frame discards it.
    rst = 1'b1;
    step(2);
    chk("rst2_full", {30'd0, sram_full1, sram_full2}, 0);
    rst = 1'b0;
    n1 = 0;
    tag1 = 4;
    send(500, 0, 4, 0, 0);
    step(1);
    chk("part_cnt", n1, 500);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n1 = 0;
    tag1 = 5;
    send(1023, 0, 5, 0, 0);
    step(3);
    chk("post_1023_full", {31'd0, sram_full1}, 0);
    send(1, 1023, 5, 0, -1);
    chk("post_last_n1", {31'd0, sram_full1}, 0);
    step(1);
    chk("post_last_n2", {31'd0, sram_full1}, 1);
    chk("post_cnt1", n1, 1024);
    chk("post_cnt2", n2, 1024);

`ifdef IMG_LOADER_FRAME_SYNC_EN
    // Stray sof at beat 300 restarts the frame at address 0.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n1 = 0;
    tag1 = 6;
    send(300, 0, 6, 0, 0);
    step(1);
    chk("sof_err_before", {31'd0, frame_err}, 0);
    n1 = 0;
    tag1 = 7;
    send(1023, 0, 7, 0, 0);
    step(2);
    chk("sof_err_after", {31'd0, frame_err}, 1);
    chk("sof_full_early", {31'd0, sram_full1}, 0);
    send(1, 1023, 7, 0, -1);
    step(1);
    chk("sof_full", {31'd0, sram_full1}, 1);
    chk("sof_cnt", n1, 1024);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
